// File: rtl/alu_pkg.sv
// Shared ALU operation codes and the multiply/divide sequencer state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_SLT   = 4'd4;
  localparam logic [3:0] ALU_SLL   = 4'd5;
  localparam logic [3:0] ALU_MULT  = 4'd6;
  localparam logic [3:0] ALU_DIV   = 4'd7;
  localparam logic [3:0] ALU_MULTU = 4'd8;
  localparam logic [3:0] ALU_DIVU  = 4'd9;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement of a pair of words, either independently or
// as one double-width value (joined) for the product.
module muldiv_sign_fix #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] src_hi,
  input  logic [WIDTH-1:0] src_lo,
  input  logic             neg_hi,
  input  logic             neg_lo,
  input  logic             joined,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  logic [2*WIDTH-1:0] wide_neg;

  assign wide_neg = -{src_hi, src_lo};

  always_comb begin
    res_hi = src_hi;
    res_lo = src_lo;
    if (joined) begin
      // neg_hi governs the whole double-width value in joined mode
      if (neg_hi) begin
        {res_hi, res_lo} = wide_neg;
      end
    end else begin
      if (neg_hi) res_hi = -src_hi;
      if (neg_lo) res_lo = -src_lo;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply / restoring divide with HI/LO result registers.
// Define MULDIV_UNSIGNED_EN to also accept MULTU/DIVU (unsigned operands).
module mul_div_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  muldiv_state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_q, q_q, opnd_q, a_orig_q, hi_q, lo_q;
  logic             sa_q, sb_q, div_q, done_q, dbz_q;

  logic             op_ok, op_div, op_signed, accept, last_iter;
  logic [WIDTH-1:0] mag_a, mag_b, res_hi, res_lo;
  logic [WIDTH:0]   add_sum, add_sel, div_rem, div_diff;
  logic [WIDTH-1:0] acc_next, q_next;
  logic             dbz;

  always_comb begin
    op_ok     = 1'b0;
    op_div    = 1'b0;
    op_signed = 1'b1;
    case (alu_op)
      ALU_MULT: op_ok = 1'b1;
      ALU_DIV: begin
        op_ok  = 1'b1;
        op_div = 1'b1;
      end
`ifdef MULDIV_UNSIGNED_EN
      ALU_MULTU: begin
        op_ok     = 1'b1;
        op_signed = 1'b0;
      end
      ALU_DIVU: begin
        op_ok     = 1'b1;
        op_div    = 1'b1;
        op_signed = 1'b0;
      end
`endif
      default: ;
    endcase
  end

  assign accept    = (state_q == StIdle) && start && op_ok;
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_opnd_fix (
    .src_hi (a),
    .src_lo (b),
    .neg_hi (op_signed & a[WIDTH-1]),
    .neg_lo (op_signed & b[WIDTH-1]),
    .joined (1'b0),
    .res_hi (mag_a),
    .res_lo (mag_b)
  );

  // Multiply: {acc,q} shifts right, adding the multiplicand when q[0] is set.
  // Divide: {acc,q} shifts left, subtracting the divisor when it fits.
  always_comb begin
    add_sum  = {1'b0, acc_q} + {1'b0, opnd_q};
    add_sel  = q_q[0] ? add_sum : {1'b0, acc_q};
    div_rem  = {acc_q, q_q[WIDTH-1]};
    div_diff = div_rem - {1'b0, opnd_q};
    if (div_q) begin
      acc_next = div_diff[WIDTH] ? div_rem[WIDTH-1:0] : div_diff[WIDTH-1:0];
      q_next   = {q_q[WIDTH-2:0], ~div_diff[WIDTH]};
    end else begin
      acc_next = add_sel[WIDTH:1];
      q_next   = {add_sel[0], q_q[WIDTH-1:1]};
    end
  end

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_res_fix (
    .src_hi (acc_q),
    .src_lo (q_q),
    .neg_hi (div_q ? sa_q : (sa_q ^ sb_q)),
    .neg_lo (sa_q ^ sb_q),
    .joined (~div_q),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  assign dbz = div_q && (opnd_q == '0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StRun;
      StRun:   if (last_iter) state_d = StFix;
      StFix:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      q_q      <= '0;
      opnd_q   <= '0;
      a_orig_q <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      div_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            q_q      <= op_div ? mag_a : mag_b;
            opnd_q   <= op_div ? mag_b : mag_a;
            a_orig_q <= a;
            sa_q     <= op_signed & a[WIDTH-1];
            sb_q     <= op_signed & b[WIDTH-1];
            div_q    <= op_div;
            dbz_q    <= 1'b0;
          end
        end
        StRun: begin
          cnt_q <= cnt_q + 1'b1;
          acc_q <= acc_next;
          q_q   <= q_next;
        end
        StFix: begin
          hi_q   <= dbz ? a_orig_q : res_hi;
          lo_q   <= dbz ? '1 : res_lo;
          dbz_q  <= dbz;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench: cycle-level reference model plus directed vectors with
// hand-computed results.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [3:0]  alu_op;
  logic [31:0] a, b;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .alu_op      (alu_op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit op_accepted(input logic [3:0] op);
`ifdef MULDIV_UNSIGNED_EN
    return (op == 4'd6) || (op == 4'd7) || (op == 4'd8) || (op == 4'd9);
`else
    return (op == 4'd6) || (op == 4'd7);
`endif
  endfunction

  // Result computed directly with 64-bit arithmetic.
  task automatic model_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] rhi, output logic [31:0] rlo,
                          output logic rdbz);
    bit          sgn = (op == 4'd6) || (op == 4'd7);
    bit          is_div = (op == 4'd7) || (op == 4'd9);
    longint      sx, sy, qq, rr;
    logic [63:0] p;
    sx = sgn ? longint'($signed(x)) : longint'({32'd0, x});
    sy = sgn ? longint'($signed(y)) : longint'({32'd0, y});
    rdbz = 1'b0;
    if (!is_div) begin
      p   = 64'(sx * sy);
      rhi = p[63:32];
      rlo = p[31:0];
    end else if (y == 32'd0) begin
      rhi  = x;
      rlo  = 32'hFFFF_FFFF;
      rdbz = 1'b1;
    end else begin
      qq  = sx / sy;
      rr  = sx % sy;
      rlo = 32'(qq);
      rhi = 32'(rr);
    end
  endtask

  int          rem_cyc = 0;
  bit          m_valid = 0;
  logic        m_busy, m_done, m_dbz, p_dbz;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;

  always @(posedge clk) begin
    if (rst) begin
      rem_cyc = 0;
      m_done  = 1'b0;
      m_dbz   = 1'b0;
      m_hi    = '0;
      m_lo    = '0;
      m_valid = 1;
    end else begin
      m_done = 1'b0;
      if (rem_cyc > 0) begin
        rem_cyc--;
        if (rem_cyc == 0) begin
          m_hi   = p_hi;
          m_lo   = p_lo;
          m_dbz  = p_dbz;
          m_done = 1'b1;
        end
      end else if (start && op_accepted(alu_op)) begin
        model_op(alu_op, a, b, p_hi, p_lo, p_dbz);
        rem_cyc = 33;
        m_dbz   = 1'b0;
      end
    end
    m_busy = (rem_cyc > 0);
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("div_by_zero", 32'(div_by_zero), 32'(m_dbz));
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
    end
  end

  // Starts at a negedge, returns at the negedge where done is seen.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edbz);
    int cyc = 0;
    start  = 1'b1;
    alu_op = op;
    a      = x;
    b      = y;
    @(negedge clk);
    start  = 1'b0;
    alu_op = 4'd0;
    a      = ~x;
    b      = ~y;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, " latency"}, 32'(cyc), 32'd33);
    chk({name, " hi"}, hi, ehi);
    chk({name, " lo"}, lo, elo);
    chk({name, " dbz"}, 32'(div_by_zero), 32'(edbz));
    chk({name, " busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int cyc;
    rst    = 1'b1;
    start  = 1'b0;
    alu_op = 4'd0;
    a      = '0;
    b      = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);

    run_op("mult 7*-3", 4'd6, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("div 100/7", 4'd7, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_op("div -7/2", 4'd7, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div 5/0", 4'd7, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
    run_op("mult 3*4", 4'd6, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);
    run_op("div ovf", 4'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    run_op("mult neg*neg", 4'd6, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'h8000_0000, 1'b0);
    run_op("div -9/-4", 4'd7, 32'hFFFF_FFF7, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'd2, 1'b0);

    // Second start while busy must be ignored.
    start  = 1'b1;
    alu_op = 4'd6;
    a      = 32'h0001_2345;
    b      = 32'h0000_0100;
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    while (!done && cyc < 40) begin
      if (cyc == 10) begin
        start  = 1'b1;
        alu_op = 4'd7;
        a      = 32'd99;
        b      = 32'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("busy-start latency", 32'(cyc), 32'd33);
    chk("busy-start hi", hi, 32'd0);
    chk("busy-start lo", lo, 32'h0123_4500);
    repeat (40) @(negedge clk);
    chk("busy-start no 2nd done", 32'(done), 32'd0);

    // Non-mul/div code is ignored.
    start  = 1'b1;
    alu_op = 4'd0;
    @(negedge clk);
    start = 1'b0;
    chk("alu_op 0 busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("alu_op 0 busy later", 32'(busy), 32'd0);

    // Reset mid-divide aborts.
    start  = 1'b1;
    alu_op = 4'd7;
    a      = 32'd1000;
    b      = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    chk("pre-reset busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort hi", hi, 32'd0);
    chk("abort lo", lo, 32'd0);
    run_op("div 1000/3", 4'd7, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Multi-cycle signed multiply/divide unit with HI/LO result registers, directly downstream of the ALU control decoder. It consumes the 4-bit ALU operation code. Codes 4'd6 (MULT) and 4'd7 (DIV) start a 32-iteration operation. All other codes belong to the single-cycle ALU and are ignored here. The control path stalls on `busy` and reads `hi`/`lo` after `done`.

Parameters:
- `WIDTH`, default 32: operand width; `hi` and `lo` are `WIDTH` bits each.
- `CNT_W`, default 6: iteration counter width; must hold the value `WIDTH`.

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request; sampled only in IDLE.
- `alu_op` in 4: ALU operation code from the ALU control stage.
- `a` in WIDTH: dividend or multiplicand (rs).
- `b` in WIDTH: divisor or multiplier (rt).
- `busy` out 1: high while an operation is in flight.
- `done` out 1: one-cycle pulse when `hi`/`lo` are updated.
- `div_by_zero` out 1: valid with `done`; set for DIV with `b`=0.
- `hi` out WIDTH: product upper half, or remainder.
- `lo` out WIDTH: product lower half, or quotient.

Behaviour:
- Reset: `rst`=1 at a clock edge forces state IDLE. After that edge: `busy`=0, `done`=0, `div_by_zero`=0, `hi`=0, `lo`=0, counter=0. Reset mid-operation aborts with no result written.
- States: IDLE, RUN, FIX.
- IDLE: if `start`=1 and `alu_op` is 6 or 7, at edge N:
  - latch the magnitudes of `a` and `b`, sign flags and op type;
  - counter=0, go to RUN, `busy`=1.
  - Otherwise stay in IDLE.
- RUN, one iteration per edge, edges N+1 .. N+WIDTH; go to FIX when counter reaches WIDTH-1.
  - MULT: shift-add, unsigned 2*WIDTH product of the magnitudes.
  - DIV: restoring division of the magnitudes.
- FIX, edge N+WIDTH+1: apply signs, write `hi`/`lo`, `done`=1 for exactly one cycle, `busy`=0 on the same edge, return to IDLE.
- Latency: `start` at edge N, result visible after edge N+33 (WIDTH=32). Fixed latency, independent of operand values.
- Sign rules:
  - product negated if sign(a)^sign(b);
  - quotient negated if sign(a)^sign(b);
  - remainder takes sign(a).
  - Arithmetic is two's complement, modulo 2^WIDTH per half.
- Overflow: 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0. This falls out of the magnitude datapath; no special case.
- Divide by zero: full latency is kept. In FIX, `hi`=`a` (original) and `lo`=all ones, with `div_by_zero`=1 alongside `done`.
- `div_by_zero` is cleared at the next accepted `start`. It is always 0 for MULT.
- `start` while `busy`=1 is ignored; there is no queueing. `start` in the same cycle that `done`=1 is accepted, since the state is IDLE by then.
- `alu_op`, `a` and `b` are ignored after acceptance. `hi`/`lo` hold their value until the next FIX.

Optional Feature:
- Macro: `MULDIV_UNSIGNED_EN`.
- Defined: codes 4'd8 (MULTU) and 4'd9 (DIVU) are also accepted. Their operands are treated as unsigned: no magnitude conversion and no sign fix. Divide-by-zero rules are identical. Latency is identical.
- Undefined: codes 8 and 9 are ignored like any other non-6/7 code. Ports are unchanged either way.

Decomposition:
- Package `alu_pkg`:
  - ALU op code constants `ALU_ADD`=0, `SUB`=1, `AND`=2, `OR`=3, `SLT`=4, `SLL`=5, `MULT`=6, `DIV`=7, `MULTU`=8, `DIVU`=9, shared with the ALU control decoder;
  - `muldiv_state_t` (IDLE/RUN/FIX) encoding.
- One sub-module, `muldiv_sign_fix`: combinational. Takes the absolute-value inputs and the final negation, i.e. the conditional two's-complement of `a`/`b` and of the results. It is instantiated once for operands and once for results. The iteration datapath stays in the top module.

Test Plan:
- MULT `a`=7, `b`=0xFFFFFFFD (-3) → after 33 cycles `done`=1, `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB, `busy` low on the same cycle.
- DIV `a`=100, `b`=7 → `lo`=14, `hi`=2. DIV `a`=-7, `b`=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIV `a`=5, `b`=0 → `hi`=5, `lo`=0xFFFFFFFF, `div_by_zero`=1. A following MULT 3*4 → `div_by_zero`=0, `hi`=0, `lo`=12.
- DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0, `div_by_zero`=0.
- `start` with MULT, then a second `start` (DIV, different operands) at cycle 10 → ignored; single `done` at cycle 33 carrying the MULT result. `start` with `alu_op`=0 → `busy` stays 0.
- `rst`=1 at cycle 15 of a DIV → `busy`=0, `hi`=`lo`=0, no `done` pulse. A new `start` next cycle completes normally.
